// File: rtl/data_mem_responder.sv
// Data-side memory responder for the core's req/gnt/rvalid data port.
// Models a word-organised data SRAM with a configurable response latency,
// optional grant throttling after every accept and a cap on the number of
// granted-but-unanswered transactions.
//
// Ports:
//   clk_i, rst_i     clock (rising edge), asynchronous active-high reset
//   data_req_i       request valid from the load/store unit
//   data_gnt_o       request accepted this cycle (combinational)
//   data_addr_i      byte address, bits [1:0] ignored
//   data_we_i        1 = write, 0 = read
//   data_be_i        byte enables, writes only
//   data_wdata_i     write data
//   data_rvalid_o    one response cycle per accepted request, in order
//   data_rdata_o     read data, zero when rvalid is low or for writes
//   data_err_o       address out of range, valid with rvalid
//   outstanding_o    current outstanding transaction count
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned AW               = 32,
  parameter int unsigned MEM_WORDS        = 1024,
  parameter int unsigned RESP_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING  = 2,
  parameter int unsigned GNT_STALL_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [AW-1:0]         data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic [2:0]            outstanding_o
);

  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned STALL_W = 3;
  localparam int unsigned NBYTES  = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [IDX_W-1:0]   idx;
  logic               in_range;
  logic               room;
  logic               accept;
  logic               unused_addr_lsbs;

  logic [CNT_W-1:0]   out_q, out_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic                  ins_valid;
  logic                  ins_err;
  logic [DATA_WIDTH-1:0] ins_data;

  logic [RESP_LATENCY-1:0] pv_q;
  logic [RESP_LATENCY-1:0] pe_q;
  logic [DATA_WIDTH-1:0]   pd_q [RESP_LATENCY];

  // Address decode: word index plus "any bit above the index field set"
  assign idx              = data_addr_i[IDX_W+1:2];
  assign in_range         = ((data_addr_i >> (IDX_W + 2)) == AW'(0));
  assign unused_addr_lsbs = ^data_addr_i[1:0];

  // An rvalid cycle frees a slot in the same cycle, so a full responder
  // can accept again while the oldest response is being returned.
  assign room = (out_q < CNT_W'(MAX_OUTSTANDING)) | data_rvalid_o;

  // Grant is held low during reset so nothing is accepted then.
  assign data_gnt_o = data_req_i & ~rst_i & room & (stall_q == STALL_W'(0));
  assign accept     = data_req_i & data_gnt_o;

  // Entry inserted into the response pipeline at the accept edge
  always_comb begin
    ins_valid = accept;
    ins_err   = accept & ~in_range;
    ins_data  = '0;
    if (accept && !data_we_i && in_range) begin
      ins_data = mem[idx];
    end
  end

  // Outstanding count and grant-stall counter next state
  always_comb begin
    out_d   = out_q;
    stall_d = stall_q;
    unique case ({accept, data_rvalid_o})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase
    if (accept) begin
      stall_d = STALL_W'(GNT_STALL_CYCLES);
    end else if (stall_q != STALL_W'(0)) begin
      stall_d = stall_q - STALL_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q   <= '0;
      stall_q <= '0;
    end else begin
      out_q   <= out_d;
      stall_q <= stall_d;
    end
  end

  // Response pipeline: stage 0 loads at the accept edge, last stage drives outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int unsigned i = 0; i < RESP_LATENCY; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= ins_valid;
      pe_q[0] <= ins_err;
      pd_q[0] <= ins_data;
      for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  // Storage array, not reset; byte-masked writes at the accept edge
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && in_range) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (data_be_i[b]) begin
          mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign data_rvalid_o = pv_q[RESP_LATENCY-1];
  assign data_err_o    = pe_q[RESP_LATENCY-1];
  assign data_rdata_o  = pd_q[RESP_LATENCY-1];
  assign outstanding_o = out_q;

endmodule
